// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// master = fetch+decode side, slave = the queue itself.
interface fetch_queue_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               push_valid;
  logic               push_ready;
  logic [INSTR_W-1:0] push_instr;
  logic [PC_W-1:0]    push_pc_plus_4;
  logic               pop_valid;
  logic               pop_ready;
  logic [INSTR_W-1:0] pop_instr;
  logic [PC_W-1:0]    pop_pc_plus_4;
  logic               flush;
  logic [CW-1:0]      count;
  logic [CNT_W-1:0]   stall_cycles;

  modport master (
    output push_valid, push_instr, push_pc_plus_4,
    output pop_ready, flush,
    input  push_ready, pop_valid, pop_instr,
    input  pop_pc_plus_4, count, stall_cycles
  );

  modport slave (
    input  push_valid, push_instr, push_pc_plus_4,
    input  pop_ready, flush,
    output push_ready, pop_valid, pop_instr,
    output pop_pc_plus_4, count, stall_cycles
  );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry circular instruction queue between fetch and decode,
// with flush, occupancy and saturating stall-cycle diagnostics.
module fetch_queue #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic [CNT_W-1:0]   r_stall;

  logic w_push_ready;
  logic w_pop_valid;
  logic w_push;
  logic w_pop;

  // Handshake flags come only from the registered count.
  assign w_push_ready = (r_count != CW'(DEPTH));
  assign w_pop_valid  = (r_count != '0);
  assign w_push = q.push_valid & w_push_ready & ~q.flush;
  assign w_pop  = w_pop_valid & q.pop_ready & ~q.flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wptr] <= q.push_instr;
      r_pc[r_wptr]    <= q.push_pc_plus_4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_stall <= '0;
    end else begin
      if (q.flush) begin
        r_rptr  <= r_wptr;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        if (w_push && !w_pop)
          r_count <= r_count + CW'(1);
        else if (w_pop && !w_push)
          r_count <= r_count - CW'(1);
      end
      if (w_pop_valid && !q.pop_ready && !q.flush &&
          r_stall != '1)
        r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign q.push_ready    = w_push_ready;
  assign q.pop_valid     = w_pop_valid;
  assign q.pop_instr     = w_pop_valid ? r_instr[r_rptr] : '0;
  assign q.pop_pc_plus_4 = w_pop_valid ? r_pc[r_rptr] : '0;
  assign q.count         = r_count;
  assign q.stall_cycles  = r_stall;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table,
// corner sequences and random traffic against a queue model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] mq[$];
  int          mstall = 0;

  typedef struct {
    logic        pv;
    logic        pr;
    logic        fl;
    logic [31:0] instr;
    int          ecount;
    logic [31:0] einstr;
    int          estall;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic chk_model();
    int c;
    logic v;
    c = mq.size();
    v = (c != 0);
    chk("count", 64'(bus.count), 64'(c));
    chk("pop_valid", 64'(bus.pop_valid), 64'(v));
    chk("push_ready", 64'(bus.push_ready), 64'(c != DEPTH));
    chk("pop_instr", 64'(bus.pop_instr),
        v ? 64'(mq[0][63:32]) : 64'd0);
    chk("pop_pc", 64'(bus.pop_pc_plus_4),
        v ? 64'(mq[0][31:0]) : 64'd0);
    chk("stall", 64'(bus.stall_cycles), 64'(mstall));
  endtask

  // Model the next edge from the current inputs, then step and compare.
  task automatic tick();
    int  c;
    logic popf, pushf;
    c = mq.size();
    if (c != 0 && !bus.pop_ready && !bus.flush && mstall < SMAX)
      mstall++;
    if (bus.flush) begin
      mq.delete();
    end else begin
      popf  = (c != 0) && bus.pop_ready;
      pushf = bus.push_valid && (c != DEPTH);
      if (popf) void'(mq.pop_front());
      if (pushf) mq.push_back({bus.push_instr, bus.push_pc_plus_4});
    end
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic drive(logic pv, logic pr, logic fl,
                       logic [31:0] ins, logic [31:0] pc);
    bus.push_valid     = pv;
    bus.pop_ready      = pr;
    bus.flush          = fl;
    bus.push_instr     = ins;
    bus.push_pc_plus_4 = pc;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    mq.delete();
    mstall = 0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    #7;
    chk("rst_count", 64'(bus.count), 0);
    chk("rst_valid", 64'(bus.pop_valid), 0);
    chk("rst_ready", 64'(bus.push_ready), 1);
    chk("rst_instr", 64'(bus.pop_instr), 0);
    chk("rst_stall", 64'(bus.stall_cycles), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    tbl[0] = '{1, 0, 0, 32'h11111111, 1, 32'h11111111, 0};
    tbl[1] = '{1, 0, 0, 32'h22222222, 2, 32'h11111111, 1};
    tbl[2] = '{1, 0, 0, 32'h33333333, 3, 32'h11111111, 2};
    tbl[3] = '{1, 0, 0, 32'h44444444, 4, 32'h11111111, 3};
    tbl[4] = '{1, 0, 0, 32'h55555555, 4, 32'h11111111, 4};
    tbl[5] = '{0, 1, 0, 32'h0, 3, 32'h22222222, 4};
    tbl[6] = '{0, 1, 0, 32'h0, 2, 32'h33333333, 4};
    tbl[7] = '{0, 1, 0, 32'h0, 1, 32'h44444444, 4};
    tbl[8] = '{0, 1, 0, 32'h0, 0, 32'h0, 4};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].pv, tbl[i].pr, tbl[i].fl, tbl[i].instr, 0);
      tick();
      chk($sformatf("tbl%0d_count", i), 64'(bus.count),
          64'(tbl[i].ecount));
      chk($sformatf("tbl%0d_ready", i), 64'(bus.push_ready),
          64'(tbl[i].ecount != DEPTH));
      chk($sformatf("tbl%0d_instr", i), 64'(bus.pop_instr),
          64'(tbl[i].einstr));
      chk($sformatf("tbl%0d_stall", i), 64'(bus.stall_cycles),
          64'(tbl[i].estall));
    end

    // Streaming across pointer wrap.
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 32'h1000 + i, 32'(4 * (i + 1)));
      tick();
      chk("stream_count", 64'(bus.count), 1);
      chk("stream_pc", 64'(bus.pop_pc_plus_4), 64'(4 * (i + 1)));
    end
    drive(0, 1, 0, 0, 0);
    tick();
    chk("stream_empty", 64'(bus.pop_valid), 0);

    // Flush beats simultaneous push and pop.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 32'hA0 + i, 32'(i));
      tick();
    end
    chk("pre_flush_count", 64'(bus.count), 3);
    drive(1, 1, 1, 32'hBAD, 32'hBAD);
    tick();
    chk("flush_count", 64'(bus.count), 0);
    chk("flush_valid", 64'(bus.pop_valid), 0);
    drive(1, 0, 0, 32'hDEADBEEF, 32'h44);
    tick();
    chk("post_flush_head", 64'(bus.pop_instr), 64'hDEADBEEF);

    // Asynchronous reset between edges.
    pulse_reset();
    drive(1, 0, 0, 32'h77, 32'h4);
    tick();
    tick();
    chk("pre_arst_count", 64'(bus.count), 2);
    chk("pre_arst_stall", 64'(bus.stall_cycles), 1);
    reset = 1'b1;
    #2;
    chk("arst_valid", 64'(bus.pop_valid), 0);
    chk("arst_count", 64'(bus.count), 0);
    chk("arst_stall", 64'(bus.stall_cycles), 0);
    chk("arst_instr", 64'(bus.pop_instr), 0);
    reset = 1'b0;
    mq.delete();
    mstall = 0;

    // Stall counter saturation.
    drive(1, 0, 0, 32'h99, 32'h8);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 64'(bus.stall_cycles), 64'(SMAX));

    // Random traffic.
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0),
            $urandom, $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction queue between fetch and decode. It generalises the single-entry fetch/decode pipeline register to DEPTH entries with a valid/ready handshake on both sides. A decode stall therefore no longer freezes fetch until the queue fills, and a branch/jump redirect flushes every queued instruction at once. Two diagnostic counters support pipeline tuning: current occupancy and saturating stall cycles.

## Interface
Parameters:
- INSTR_W, 32, instruction width
- PC_W, 32, width of the pc_plus_4 field
- DEPTH, 4, number of entries; power of two, at least 2
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- push_valid  in  1  fetch presents an instruction
- push_ready  out  1  queue can accept; equals (count != DEPTH)
- push_instr  in  INSTR_W  fetched instruction
- push_pc_plus_4  in  PC_W  PC+4 of the fetched instruction
- pop_valid  out  1  head entry valid; equals (count != 0)
- pop_ready  in  1  decode consumes the head this cycle (the inverse of StallD)
- pop_instr  out  INSTR_W  head instruction; 0 (NOP) when empty
- pop_pc_plus_4  out  PC_W  head PC+4; 0 when empty
- flush  in  1  redirect (PCSrc/jump); discards all entries
- count  out  $clog2(DEPTH)+1  current occupancy
- stall_cycles  out  CNT_W  saturating count of cycles with pop_valid=1 and pop_ready=0

## Operation
- Storage: circular buffer of DEPTH entries, each {instr, pc_plus_4}.
- Pointers: write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy: count register, 0..DEPTH inclusive.
- Push fire: push_valid & push_ready & !flush. Writes the entry at the write pointer, then increments the write pointer.
- Pop fire: pop_valid & pop_ready & !flush. Increments the read pointer.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged when push and pop fire together (legal at any count 1..DEPTH-1)
- Full (count = DEPTH): push_ready=0. There is no same-cycle bypass: a push with a simultaneous pop while full is not accepted.
- Empty (count = 0): pop_valid=0 and outputs are forced to 0. There is no fall-through: a pushed instruction is visible at the pop side one cycle later.
- Flush has priority over push and pop. On the next edge:
  - count=0
  - read pointer = write pointer
  - storage contents don't care
  - a push presented in the flush cycle is dropped
- stall_cycles increments on every edge where pop_valid & !pop_ready & !flush. It holds at 2^CNT_W-1. It is cleared only by reset.
- Outputs pop_instr and pop_pc_plus_4 are a combinational read of the head entry, masked by pop_valid.

## Timing
- Reset (asserted asynchronously, held any length):
  - count=0, pop_valid=0, push_ready=1
  - pop_instr=0, pop_pc_plus_4=0, stall_cycles=0
  - both pointers 0
- First rising edge after reset deassertion performs normal operation.
- Latency push to pop_valid: 1 cycle.
- Throughput: 1 instruction per cycle sustained with push_valid and pop_ready both held high.
- push_ready and pop_valid depend only on registered count, with no combinational path from push_valid/pop_ready. This avoids loops with the hazard unit.
- Reset mid-operation: all entries are lost and the outputs go to their reset values within the same cycle, without waiting for a clock edge.
- Pointer wrap: the write pointer going from DEPTH-1 to 0 while the read pointer is at 0 yields count=DEPTH (full, not empty). Full and empty are distinguished by count only.

## Test plan
- Reset then fill: DEPTH=4, push 0x11111111..0x44444444 with pop_ready=0 -> count 1,2,3,4; push_ready=0 after the 4th; 5th push is ignored; stall_cycles=3 after the 4th edge.
- Drain in order: after fill, pop_ready=1 for 4 cycles -> pop_instr sequence 0x11111111,0x22222222,0x33333333,0x44444444, then pop_valid=0 and pop_instr=0.
- Streaming with wrap: push and pop every cycle for 10 cycles with pc_plus_4 = 4,8,...,40 -> count stays 1 after the first edge; pc_plus_4 values appear one cycle later in order across pointer wrap.
- Flush priority: count=3, assert flush with push_valid=1 and pop_ready=1 -> next cycle count=0, pop_valid=0; a push next cycle of 0xDEADBEEF appears at the head one cycle after that.
- Async reset mid-stream: count=2, assert reset between edges -> pop_valid, count, stall_cycles and pop_instr read 0 before the next edge.
- Saturation: CNT_W=4, hold pop_valid=1 and pop_ready=0 for 20 cycles -> stall_cycles reaches 15 and holds.
